// File: rtl/rx_pd_sfd.sv
// BPSK packet detector: counts 0101 preamble alternations to lock, then hunts for the
// SFD in either polarity (resolving the 180 degree ambiguity) with an optional timeout.
module rx_pd_sfd #(
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int MAX_ERR_WIDTH    = 4,
  parameter int SFD_WIDTH        = 16,
  parameter int TIMEOUT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_enable,
  input  logic [MAX_WINDOW_WIDTH-1:0] RX_PD_WINDOW,
  input  logic [MAX_ERR_WIDTH-1:0]    RX_PD_MAX_ERR,
  input  logic [SFD_WIDTH-1:0]        RX_SFD_PATTERN,
  input  logic [TIMEOUT_WIDTH-1:0]    RX_SFD_TIMEOUT,
  input  logic                        BPSK,
  input  logic                        SD_flag,
  input  logic                        disassert_PD,
  output logic                        PD_flag,
  output logic                        SFD_flag,
  output logic                        SFD_inverted,
  output logic                        sfd_timeout,
  output logic [1:0]                  fsm_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FRAME  = 2'd2
  } state_t;

  localparam logic [MAX_WINDOW_WIDTH-1:0] CNT_ONE  = MAX_WINDOW_WIDTH'(1);
  localparam logic [MAX_ERR_WIDTH:0]      ERR_ONE  = (MAX_ERR_WIDTH + 1)'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]    TCNT_ONE = TIMEOUT_WIDTH'(1);

  state_t                      state, state_nxt;
  logic [MAX_WINDOW_WIDTH-1:0] cnt, cnt_nxt;
  logic [MAX_ERR_WIDTH-1:0]    err, err_nxt;
  logic [TIMEOUT_WIDTH-1:0]    tcnt, tcnt_nxt;
  logic [SFD_WIDTH-1:0]        sr, sr_nxt;
  logic                        bpsk_reg, bpsk_reg_nxt;
  logic                        pd_nxt, sfd_nxt, inv_nxt, tmo_nxt;
  logic                        diff;
  logic [MAX_ERR_WIDTH:0]      err_inc;

  assign fsm_state = state;
  assign diff      = BPSK ^ bpsk_reg;
  // One bit wider so err = all-ones still compares correctly against the limit.
  assign err_inc   = {1'b0, err} + ERR_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEARCH;
      cnt          <= '0;
      err          <= '0;
      tcnt         <= '0;
      sr           <= '0;
      bpsk_reg     <= 1'b0;
      PD_flag      <= 1'b0;
      SFD_flag     <= 1'b0;
      SFD_inverted <= 1'b0;
      sfd_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      err          <= err_nxt;
      tcnt         <= tcnt_nxt;
      sr           <= sr_nxt;
      bpsk_reg     <= bpsk_reg_nxt;
      PD_flag      <= pd_nxt;
      SFD_flag     <= sfd_nxt;
      SFD_inverted <= inv_nxt;
      sfd_timeout  <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    err_nxt      = err;
    tcnt_nxt     = tcnt;
    sr_nxt       = sr;
    bpsk_reg_nxt = bpsk_reg;
    pd_nxt       = PD_flag;
    sfd_nxt      = 1'b0;
    inv_nxt      = SFD_inverted;
    tmo_nxt      = 1'b0;
    if (clk_enable) begin
      bpsk_reg_nxt = BPSK;
      sr_nxt       = {sr[SFD_WIDTH-2:0], BPSK};
      // Loss of signal or end of packet overrides whatever the FSM was doing.
      if (!SD_flag || disassert_PD) begin
        state_nxt = SEARCH;
        cnt_nxt   = '0;
        err_nxt   = '0;
        tcnt_nxt  = '0;
        pd_nxt    = 1'b0;
      end else begin
        unique case (state)
          SEARCH: begin
            if (cnt >= RX_PD_WINDOW) begin
              state_nxt = LOCKED;
              pd_nxt    = 1'b1;
              tcnt_nxt  = '0;
            end else if (diff) begin
              if (cnt != '1) cnt_nxt = cnt + CNT_ONE;
            end else if (err_inc > {1'b0, RX_PD_MAX_ERR}) begin
              cnt_nxt = '0;
              err_nxt = '0;
            end else begin
              err_nxt = err_inc[MAX_ERR_WIDTH-1:0];
            end
          end
          LOCKED: begin
            if (sr_nxt == RX_SFD_PATTERN) begin
              sfd_nxt   = 1'b1;
              inv_nxt   = 1'b0;
              state_nxt = FRAME;
            end else if (sr_nxt == ~RX_SFD_PATTERN) begin
              sfd_nxt   = 1'b1;
              inv_nxt   = 1'b1;
              state_nxt = FRAME;
            end else if ((RX_SFD_TIMEOUT != '0) && (tcnt == RX_SFD_TIMEOUT - TCNT_ONE)) begin
              tmo_nxt   = 1'b1;
              pd_nxt    = 1'b0;
              state_nxt = SEARCH;
              cnt_nxt   = '0;
              err_nxt   = '0;
            end else begin
              tcnt_nxt = tcnt + TCNT_ONE;
            end
          end
          FRAME:   state_nxt = FRAME;
          default: state_nxt = SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_pd_sfd.sv
// Bench for rx_pd_sfd: directed scenarios plus randomized traffic, compared every clock
// against a symbol-history reference model.
module tb_rx_pd_sfd;
  localparam int WW = 8, EW = 4, SW = 16, TW = 16;

  logic          clk = 1'b0;
  logic          rst, clk_enable, BPSK, SD_flag, disassert_PD;
  logic [WW-1:0] RX_PD_WINDOW;
  logic [EW-1:0] RX_PD_MAX_ERR;
  logic [SW-1:0] RX_SFD_PATTERN;
  logic [TW-1:0] RX_SFD_TIMEOUT;
  logic          PD_flag, SFD_flag, SFD_inverted, sfd_timeout;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  rx_pd_sfd #(.MAX_WINDOW_WIDTH(WW), .MAX_ERR_WIDTH(EW), .SFD_WIDTH(SW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .RX_PD_WINDOW(RX_PD_WINDOW), .RX_PD_MAX_ERR(RX_PD_MAX_ERR),
    .RX_SFD_PATTERN(RX_SFD_PATTERN), .RX_SFD_TIMEOUT(RX_SFD_TIMEOUT),
    .BPSK(BPSK), .SD_flag(SD_flag), .disassert_PD(disassert_PD),
    .PD_flag(PD_flag), .SFD_flag(SFD_flag), .SFD_inverted(SFD_inverted),
    .sfd_timeout(sfd_timeout), .fsm_state(fsm_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = hunting preamble, 1 = locked/hunting SFD, 2 = in frame.
  int m_mode, m_cnt, m_err, m_tcnt;
  bit m_prev, m_pd, m_sfd, m_inv, m_to;
  bit hist[$];

  function automatic int window_value();
    int v = 0;
    foreach (hist[i]) v = (v << 1) | int'(hist[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_err = 0; m_tcnt = 0;
    m_prev = 0; m_pd = 0; m_sfd = 0; m_inv = 0; m_to = 0;
    hist.delete();
    repeat (SW) hist.push_back(1'b0);
  endtask

  task automatic model_step(bit en, bit b, bit sd, bit dis);
    int pat, npat, win;
    bit changed;
    m_sfd = 0;
    m_to  = 0;
    if (!en) return;
    changed = (b != m_prev);
    m_prev  = b;
    hist.push_back(b);
    void'(hist.pop_front());
    win  = window_value();
    pat  = int'(RX_SFD_PATTERN);
    npat = (~pat) & ((1 << SW) - 1);
    if (!sd || dis) begin
      m_mode = 0; m_cnt = 0; m_err = 0; m_tcnt = 0; m_pd = 0;
    end else if (m_mode == 0) begin
      if (m_cnt >= int'(RX_PD_WINDOW)) begin
        m_mode = 1; m_pd = 1; m_tcnt = 0;
      end else if (changed) begin
        if (m_cnt < (1 << WW) - 1) m_cnt++;
      end else if (m_err + 1 > int'(RX_PD_MAX_ERR)) begin
        m_cnt = 0; m_err = 0;
      end else begin
        m_err++;
      end
    end else if (m_mode == 1) begin
      if (win == pat) begin
        m_sfd = 1; m_inv = 0; m_mode = 2;
      end else if (win == npat) begin
        m_sfd = 1; m_inv = 1; m_mode = 2;
      end else if (RX_SFD_TIMEOUT != 0 && m_tcnt == int'(RX_SFD_TIMEOUT) - 1) begin
        m_to = 1; m_pd = 0; m_mode = 0; m_cnt = 0; m_err = 0;
      end else begin
        m_tcnt++;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(bit en, bit b, bit sd = 1, bit dis = 0, bit r = 0);
    clk_enable = en; BPSK = b; SD_flag = sd; disassert_PD = dis; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else model_step(en, b, sd, dis);
    #1;
    check("PD_flag", 32'(PD_flag), 32'(m_pd));
    check("SFD_flag", 32'(SFD_flag), 32'(m_sfd));
    check("SFD_inverted", 32'(SFD_inverted), 32'(m_inv));
    check("sfd_timeout", 32'(sfd_timeout), 32'(m_to));
    check("fsm_state", 32'(fsm_state), 32'(m_mode));
  endtask

  task automatic send_word(logic [SW-1:0] w);
    for (int i = SW - 1; i >= 0; i--) step(1, w[i]);
  endtask

  task automatic alternate(int n);
    for (int i = 0; i < n; i++) step(1, ~BPSK);
  endtask

  initial begin
    int rise_at, to_at, k, pulses, pidx;
    bit pd_seen, pinv, b, en;
    logic [SW-1:0] w;

    RX_PD_WINDOW = 8; RX_PD_MAX_ERR = 0; RX_SFD_PATTERN = 16'hF3A0; RX_SFD_TIMEOUT = 0;
    clk_enable = 0; BPSK = 0; SD_flag = 1; disassert_PD = 0; rst = 1;
    model_reset();
    step(0, 0, 1, 0, 1);
    step(1, 1, 1, 0, 1);

    // Clean preamble starting with a 0 symbol: lock on the 10th enabled cycle.
    rise_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1, (i % 2) == 0);
      if (PD_flag && rise_at < 0) rise_at = i;
    end
    check("pd_rise_cycle", 32'(rise_at), 32'd10);

    // Repeated symbol at symbol 5 restarts the count.
    step(1, 0, 1, 0, 1);
    foreach (w[i]) w[i] = 1'b0;
    for (int i = 1; i <= 20; i++) step(1, (i <= 4) ? ((i % 2) == 0) : ((i % 2) == 1));

    // Error tolerance of two: two glitches survive, a third resets the count.
    RX_PD_MAX_ERR = 2;
    step(1, 0, 1, 0, 1);
    alternate(4); step(1, BPSK); alternate(3); step(1, BPSK); alternate(2); step(1, BPSK);
    alternate(12);
    step(1, 0, 1, 0, 1);
    alternate(3); step(1, BPSK); alternate(3); step(1, BPSK); alternate(8);

    // SFD in true polarity, then inverted after re-lock.
    RX_PD_MAX_ERR = 0;
    step(1, 0, 1, 0, 1);
    alternate(12);
    pulses = 0;
    for (int i = SW - 1; i >= 0; i--) begin
      step(1, RX_SFD_PATTERN[i]);
      pulses += int'(SFD_flag);
    end
    check("sfd_pulses_true", 32'(pulses), 32'd1);
    check("sfd_inv_true", 32'(SFD_inverted), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 1'($urandom_range(0, 1)));
    check("pd_held_frame", 32'(PD_flag), 32'd1);
    step(1, 0, 0);
    alternate(12);
    send_word(~RX_SFD_PATTERN);
    check("sfd_inv_inverted", 32'(SFD_inverted), 32'd1);
    step(1, 1, 1, 1);
    check("release_disassert", 32'(PD_flag), 32'd0);
    alternate(12);
    send_word(RX_SFD_PATTERN);
    step(1, 0, 0);
    check("release_sd", 32'(fsm_state), 32'd0);

    // SFD timeout of 32 locked cycles under continued alternation.
    RX_SFD_TIMEOUT = 32;
    step(1, 0, 1, 0, 1);
    pd_seen = 0; k = 0; to_at = -1;
    for (int i = 0; i < 80; i++) begin
      step(1, ~BPSK);
      if (pd_seen) k++;
      if (sfd_timeout) begin
        to_at = k;
        break;
      end
      if (PD_flag) pd_seen = 1;
    end
    check("timeout_cycle", 32'(to_at), 32'd32);
    alternate(12);
    check("relock_after_timeout", 32'(PD_flag), 32'd1);
    step(1, 0, 1, 0, 1);
    RX_SFD_TIMEOUT = 0;
    alternate(100);
    check("no_timeout_when_zero", 32'(PD_flag), 32'd1);
    step(1, ~BPSK, 1, 0, 1);
    check("rst_mid_locked", 32'(PD_flag), 32'd0);

    // Quarter-rate symbol strobe.
    for (int i = 0; i < 24; i++) begin
      repeat (3) step(0, 1'($urandom_range(0, 1)));
      step(1, ~BPSK);
    end
    send_word(RX_SFD_PATTERN);

    // Randomized traffic with live config changes and injected SFDs.
    pidx = 0; pinv = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        RX_PD_WINDOW   = WW'($urandom_range(0, 12));
        RX_PD_MAX_ERR  = EW'($urandom_range(0, 3));
        RX_SFD_TIMEOUT = ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(5, 40));
        RX_SFD_PATTERN = SW'($urandom);
      end
      en = ($urandom_range(0, 3) != 0);
      if (m_mode == 1 && pidx == 0 && $urandom_range(0, 7) == 0) begin
        pidx = SW;
        pinv = 1'($urandom_range(0, 1));
      end
      if (pidx > 0) b = RX_SFD_PATTERN[pidx-1] ^ pinv;
      else b = ($urandom_range(0, 7) == 0) ? BPSK : ~BPSK;
      if (en && pidx > 0) pidx--;
      step(en, b, $urandom_range(0, 63) != 0, $urandom_range(0, 127) == 0,
           $urandom_range(0, 255) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
